// File: rtl/uart_tx_sniffer_if.sv
// Byte stream handshake from the UART sniffer to its consumer.
// master drives valid/data, slave drives ready.
interface uart_tx_sniffer_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/uart_tx_sniffer.sv
// Passive 8N1 decoder of a UART TX pin feeding a small FWFT byte FIFO.
// Define UART_SNIFF_MAJORITY_EN for 3-sample majority voting per bit.
module uart_tx_sniffer #(
    parameter int DIV        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    uart_tx_sniffer_if.master    stream,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIV) + 1;

`ifdef UART_SNIFF_MAJORITY_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    // Last counter value of each phase; majority voting decides one cycle later.
    localparam logic [CW-1:0] START_LAST = CW'(DIV / 2 - 1 + LAG);
    localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);
    localparam logic [AW:0]   FULL       = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic sync1;
    logic rxs;
    logic hist1;
    logic samp;

`ifdef UART_SNIFF_MAJORITY_EN
    logic hist2;

    // Synchronize rxd and keep two cycles of history for the vote.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            hist1 <= 1'b1;
            hist2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            hist1 <= rxs;
            hist2 <= hist1;
        end
    end

    assign samp = (rxs & hist1) | (rxs & hist2) | (hist1 & hist2);
`else
    // Synchronize rxd and keep the previous value for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
            hist1 <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
            hist1 <= rxs;
        end
    end

    assign samp = rxs;
`endif

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          push;
    logic          ferr_d;

    // Decoder state, bit timer, bit index and shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: start detect, mid-bit sampling, stop check.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs && hist1) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == START_LAST) begin
                    cnt_d = '0;
                    if (samp) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {samp, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (samp) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // Framing error is a registered single-cycle pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_d;
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic          pop;
    logic          full;
    logic          accept;

    assign pop    = (count_q != '0) && stream.out_ready;
    assign full   = (count_q == FULL);
    // A push into a full FIFO survives only if the head leaves this cycle.
    assign accept = push && (!full || pop);

    // FIFO storage, pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_q] <= shift_q;
                wr_q      <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    assign stream.out_valid = (count_q != '0);
    assign stream.out_data  = mem[rd_q];

endmodule

// File: doc/uart_tx_sniffer.md
# uart_tx_sniffer

Passive 8N1 serial decoder for the simulation harness. It samples the DUT's UART transmit pin and turns it into a byte stream with a valid/ready handshake. It sits directly upstream of the UART console/end-of-test monitor and feeds that monitor, so the monitor never probes internal UART signals. It buffers bytes in a small FIFO and flags framing errors and overflow.

## Interface
- DIV, 16: clock cycles per bit period; even, ≥ 4.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥ 2.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- rxd  in  1  DUT UART TX pin, asynchronous to clock; idle high.
- out_valid  out  1  FIFO head holds a byte.
- out_ready  in  1  consumer accepts the head byte.
- out_data  out  8  FIFO head byte; undefined when out_valid=0.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- busy  out  1  decoder state ≠ IDLE.

## Operation
- rxd passes through a 2-flop synchronizer, reset to 1; `rxs` is the synchronized value.
- Edge detect: cycle E is the first cycle with `rxs`=0 and previous `rxs`=1, while in IDLE.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on E, go to START and clear the bit counter.
- START: sample at E + DIV/2.
  - Sample 1 means a false start: return to IDLE, nothing pushed.
  - Sample 0: go to DATA with bit index 0.
- DATA: data bit k (0..7) is sampled at E + DIV/2 + (k+1)·DIV and shifted in LSB first. After bit 7, go to STOP.
- STOP: sample at E + DIV/2 + 9·DIV.
  - Sample 1: push the byte and go to IDLE.
  - Sample 0: pulse frame_err for one cycle, discard the byte, go to BREAK.
- BREAK: wait for `rxs`=1, then go to IDLE. A new start bit is only detected from IDLE.
- FIFO push when full:
  - If the same cycle pops (out_valid && out_ready), the push is accepted and the count is unchanged.
  - Otherwise the byte is dropped and overflow is set.
- overflow clears only on reset.
- Pop occurs when out_valid && out_ready. out_data holds stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values: out_valid=0, out_data=0, frame_err=0, overflow=0, busy=0. FSM=IDLE, FIFO empty, synchronizer flops=1.
- Reset asserted mid-frame: all state returns to reset values on the next edge and the partial byte is lost. The first full frame after reset release decodes correctly.
- Synchronizer latency: E = cycle of the raw rxd fall + 2.
- Push latency: out_valid rises on the cycle after the stop-bit sample, at raw fall + 2 + DIV/2 + 9·DIV + 1. For DIV=16 this is 155 cycles.
- The FIFO is first-word-fall-through: a push into an empty FIFO is visible on out_valid the next cycle.
- frame_err fires on the cycle after the stop-bit sample.
- busy is high from E+1 until the cycle after returning to IDLE.
- Back-to-back frames: the next start edge may occur one bit period after the stop-bit centre. The decoder is back in IDLE by then.

## Configuration
- UART_SNIFF_MAJORITY_EN defined:
  - Each sample point S (start, data, stop) uses the majority of `rxs` at S-1, S and S+1.
  - The decision is taken at S+1, so every sample-derived event (false-start abort, bit shift, push, frame_err) moves one cycle later. Push latency becomes raw fall + 2 + DIV/2 + 9·DIV + 2.
- Undefined: single sample of `rxs` at S, with the latencies listed above.

## Test plan
- DIV=16, drive 0x55 framed 8N1 with out_ready=1 -> out_data=0x55, out_valid high for exactly one cycle, 155 cycles after the rxd fall (156 with the macro).
- Five frames 0x01..0x05 with out_ready=0 and FIFO_DEPTH=4 -> out_valid=1 with 0x01 at the head, overflow=1 after the 5th stop bit. Then raise out_ready -> 0x01..0x04 popped in order, 0x05 never appears.
- Frame 0x3C with the stop bit driven low -> frame_err pulses once, no push. With rxd held low for 40 cycles, busy stays 1 until rxd returns high, then the next 0x7E frame decodes correctly.
- 3-cycle low glitch on idle rxd -> false start at E+8, no push, no frame_err, busy drops to 0.
- Reset pulsed during data bit 4 of 0xA5 -> all outputs at reset values next cycle. A following 0xC3 frame yields exactly one byte, 0xC3.
- 0xA5 with a 1-cycle inverted glitch at bit 2's centre -> 0xA5 with UART_SNIFF_MAJORITY_EN defined; 0xA1 without it.
